// File: rtl/instr_byte_loader_pkg.sv
// rtl/instr_byte_loader_pkg.sv - shared types and constants for the instruction byte loader
// Purpose: 2-bit FSM state encodings, endian selectors, default terminator word,
//          and the byte-placement helper used by the word assembler.
// Ports:   none (package).
package instr_byte_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int ENDIAN_BIG    = 1;
  localparam int ENDIAN_LITTLE = 0;

  localparam logic [31:0] DEFAULT_END_WORD = 32'hFFFF_FFFF;

  // Big-endian shifts left so the first byte ends up in [31:24] after four
  // shifts; little-endian shifts right so the first byte ends up in [7:0].
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [7:0]  data,
                                             input bit          big_endian);
    if (big_endian) return {word[23:0], data};
    else            return {data, word[31:8]};
  endfunction

endpackage

// File: rtl/instr_byte_loader_idle_timer.sv
// rtl/instr_byte_loader_idle_timer.sv - inter-byte idle counter with clear/enable/expire
// Purpose: counts idle cycles while enabled; expire is asserted during the
//          cycle in which the count would reach LIMIT.
// Ports:   clock, reset_n (async active-low), clear, enable in; expire out.
module byte_idle_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // Fires on the LIMIT-th consecutive idle cycle so the owner can abort at
  // the same edge the count reaches LIMIT.
  assign expire = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/instr_byte_loader.sv
// rtl/instr_byte_loader.sv - byte stream to 32-bit instruction word loader
// Purpose: accepts bytes over valid/ready, assembles 32-bit words, presents each
//          on instr_out with a one-cycle write_instr strobe; a load ends on the
//          terminator word, the word limit, or an inter-byte timeout.
// Ports:   clock, reset_n (async active-low), start, byte_valid, byte_data[7:0] in;
//          byte_ready, instr_out[31:0], write_instr, word_count[CW-1:0],
//          load_active, load_done, load_err out.
module instr_byte_loader
  import instr_byte_loader_pkg::*;
#(
  parameter int          BIG_ENDIAN     = ENDIAN_BIG,
  parameter logic [31:0] END_WORD       = DEFAULT_END_WORD,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1024,
  localparam int         CW             = $clog2(MAX_WORDS + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic [31:0]   instr_out,
  output logic          write_instr,
  output logic [CW-1:0] word_count,
  output logic          load_active,
  output logic          load_done,
  output logic          load_err
);

  state_t        state;
  state_t        state_next;
  logic [31:0]   shift_reg;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_full;
  logic [CW-1:0] word_count_inc;
  logic          transfer;
  logic          last_byte;
  logic          start_accept;
  logic          timer_clear;
  logic          timer_enable;
  logic          timeout;

  assign byte_ready     = (state == ST_ASSEMBLE);
  assign load_active    = (state == ST_ASSEMBLE) || (state == ST_EMIT);
  assign load_done      = (state == ST_DONE);
  assign transfer       = byte_valid && byte_ready;
  assign last_byte      = transfer && (byte_cnt == 2'd3);
  assign start_accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign word_full      = place_byte(shift_reg, byte_data, BIG_ENDIAN != 0);
  assign word_count_inc = word_count + CW'(1);

  // Only a partially assembled word can time out; an empty assembler waits forever.
  assign timer_clear  = transfer || (state != ST_ASSEMBLE);
  assign timer_enable = (state == ST_ASSEMBLE) && (byte_cnt != 2'd0) && !transfer;

  byte_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expire  (timeout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // In EMIT, write_instr doubles as "this word is not the terminator".
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_ASSEMBLE;
      end
      ST_ASSEMBLE: begin
        if (timeout)        state_next = ST_IDLE;
        else if (last_byte) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (!write_instr)                            state_next = ST_DONE;
        else if (word_count_inc == CW'(MAX_WORDS))   state_next = ST_DONE;
        else                                         state_next = ST_ASSEMBLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg   <= '0;
      byte_cnt    <= '0;
      instr_out   <= '0;
      write_instr <= 1'b0;
      word_count  <= '0;
      load_err    <= 1'b0;
    end else begin
      write_instr <= last_byte && (word_full != END_WORD);
      if (start_accept) begin
        byte_cnt   <= '0;
        word_count <= '0;
        load_err   <= 1'b0;
      end
      if (transfer) begin
        shift_reg <= word_full;
        byte_cnt  <= byte_cnt + 2'd1;
      end
      if (last_byte) begin
        instr_out <= word_full;
      end
      if ((state == ST_EMIT) && write_instr) begin
        word_count <= word_count_inc;
      end
      if (timeout) begin
        load_err <= 1'b1;
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instr_byte_loader.sv
// tb/tb_instr_byte_loader.sv - self-checking bench for instr_byte_loader
// Purpose: drives one shared byte stream into three loader configurations
//          (big-endian, little-endian, two-word limit) and checks strobes via
//          per-instance scoreboards plus status snapshots against a word-level model.
// Ports:   none (top-level bench).
module tb_instr_byte_loader;

  localparam int          TO   = 16;
  localparam logic [31:0] ENDW = 32'hFFFF_FFFF;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic [2:0]  ready;
  logic [2:0]  wr;
  logic [2:0]  act;
  logic [2:0]  done;
  logic [2:0]  err;
  logic [31:0] instr [3];
  logic [8:0]  wc0;
  logic [8:0]  wc1;
  logic [1:0]  wc2;

  instr_byte_loader #(.BIG_ENDIAN(1), .MAX_WORDS(256), .TIMEOUT_CYCLES(TO)) dut_be (
    .clock(clock), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready[0]), .instr_out(instr[0]),
    .write_instr(wr[0]), .word_count(wc0), .load_active(act[0]),
    .load_done(done[0]), .load_err(err[0]));

  instr_byte_loader #(.BIG_ENDIAN(0), .MAX_WORDS(256), .TIMEOUT_CYCLES(TO)) dut_le (
    .clock(clock), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready[1]), .instr_out(instr[1]),
    .write_instr(wr[1]), .word_count(wc1), .load_active(act[1]),
    .load_done(done[1]), .load_err(err[1]));

  instr_byte_loader #(.BIG_ENDIAN(1), .MAX_WORDS(2), .TIMEOUT_CYCLES(TO)) dut_mw (
    .clock(clock), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(ready[2]), .instr_out(instr[2]),
    .write_instr(wr[2]), .word_count(wc2), .load_active(act[2]),
    .load_done(done[2]), .load_err(err[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  b [4];
    logic [31:0] be;
    logic [31:0] le;
  } vec_t;

  vec_t tbl [6];

  int passed = 0;
  int total  = 0;

  bit          m_active [3];
  bit          m_done   [3];
  bit          m_err    [3];
  int          m_cnt    [3];
  int          m_bcnt   [3];
  logic [31:0] m_last   [3];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [2:0]  wr_prev = '0;

  function automatic bit inst_be(input int i);
    return i != 1;
  endfunction

  function automatic int inst_max(input int i);
    return (i == 2) ? 2 : 256;
  endfunction

  function automatic int wc(input int i);
    case (i)
      0:       return int'(wc0);
      1:       return int'(wc1);
      default: return int'(wc2);
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(input int i, input logic [31:0] w);
    case (i)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endfunction

  function automatic logic [31:0] qpop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void set_vec(input int idx, input logic [31:0] bytes_in,
                                  input logic [31:0] be, input logic [31:0] le);
    tbl[idx].b[0] = bytes_in[31:24];
    tbl[idx].b[1] = bytes_in[23:16];
    tbl[idx].b[2] = bytes_in[15:8];
    tbl[idx].b[3] = bytes_in[7:0];
    tbl[idx].be   = be;
    tbl[idx].le   = le;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Strobe monitor: every write_instr pops one expected word and must drop after one cycle.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (wr_prev[i]) chk($sformatf("strobe_width[%0d]", i), {31'b0, wr[i]}, 32'd0);
      if (wr[i]) begin
        if (qsize(i) == 0) chk($sformatf("spurious_strobe[%0d]", i), {31'b0, wr[i]}, 32'd0);
        else chk($sformatf("strobe_word[%0d]", i), instr[i], qpop(i));
      end
    end
    wr_prev = wr;
  end

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 0; m_done[i] = 0; m_err[i] = 0;
      m_cnt[i] = 0; m_bcnt[i] = 0; m_last[i] = '0;
    end
    q0.delete(); q1.delete(); q2.delete();
  endfunction

  function automatic void model_byte(input int row);
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      if (m_active[i]) begin
        m_bcnt[i]++;
        if (m_bcnt[i] == 4) begin
          m_bcnt[i] = 0;
          w = inst_be(i) ? tbl[row].be : tbl[row].le;
          m_last[i] = w;
          if (w == ENDW) begin
            m_active[i] = 0; m_done[i] = 1;
          end else begin
            qpush(i, w);
            m_cnt[i]++;
            if (m_cnt[i] == inst_max(i)) begin
              m_active[i] = 0; m_done[i] = 1;
            end
          end
        end
      end
    end
  endfunction

  function automatic void model_timeout();
    for (int i = 0; i < 3; i++) begin
      if (m_active[i] && m_bcnt[i] != 0) begin
        m_active[i] = 0; m_err[i] = 1; m_bcnt[i] = 0;
      end
    end
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!m_active[i]) begin
        m_active[i] = 1; m_done[i] = 0; m_err[i] = 0; m_cnt[i] = 0; m_bcnt[i] = 0;
      end
    end
    tick();
    start = 1'b0;
  endtask

  // Called at a falling edge; ready is stable until the next rising edge, so
  // the model is updated before the edge at which the transfer takes place.
  task automatic send_byte(input int row, input int k);
    int budget;
    bit r;
    bit ok;
    budget = 40;
    ok = 0;
    byte_valid = 1'b1;
    byte_data  = tbl[row].b[k];
    while (budget > 0 && !ok) begin
      r = ready[0];
      if (r) model_byte(row);
      tick();
      ok = r;
      budget--;
    end
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    if (!ok) begin
      total++;
      $display("FAIL byte_accept: row %0d byte %0d never accepted, ready=%b", row, k, ready);
    end
  endtask

  task automatic send_bytes(input int row, input int nbytes, input int maxgap, input int start_at);
    for (int k = 0; k < nbytes; k++) begin
      repeat (int'($urandom_range(0, maxgap))) tick();
      if (k == start_at) start_pulse();
      send_byte(row, k);
    end
  endtask

  task automatic check_status(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.load_active[%0d]", tag, i), {31'b0, act[i]},   {31'b0, m_active[i]});
      chk($sformatf("%s.byte_ready[%0d]", tag, i),  {31'b0, ready[i]}, {31'b0, m_active[i]});
      chk($sformatf("%s.load_done[%0d]", tag, i),   {31'b0, done[i]},  {31'b0, m_done[i]});
      chk($sformatf("%s.load_err[%0d]", tag, i),    {31'b0, err[i]},   {31'b0, m_err[i]});
      chk($sformatf("%s.word_count[%0d]", tag, i),  wc(i),             m_cnt[i]);
      chk($sformatf("%s.instr_out[%0d]", tag, i),   instr[i],          m_last[i]);
      chk($sformatf("%s.pending[%0d]", tag, i),     qsize(i),          32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_vec(0, 32'h2008_0005, 32'h2008_0005, 32'h0500_0820);
    set_vec(1, 32'h8C09_0004, 32'h8C09_0004, 32'h0400_098C);
    set_vec(2, 32'h0500_0820, 32'h0500_0820, 32'h2008_0005);
    set_vec(3, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFEFF_FFFF);
    set_vec(4, 32'h1234_5678, 32'h1234_5678, 32'h7856_3412);
    set_vec(5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    model_reset();
    repeat (3) tick();
    check_status("reset");
    reset_n = 1'b1;
    tick();

    // Full-rate table load; the two-word instance stops after row 1.
    start_pulse();
    for (int r = 0; r < 6; r++) send_bytes(r, 4, 0, -1);
    repeat (2) tick();
    check_status("table");

    // Timeout boundary: two bytes, then idle.
    start_pulse();
    check_status("restart");
    send_bytes(4, 2, 0, -1);
    repeat (TO - 1) tick();
    check_status("pre_timeout");
    tick();
    model_timeout();
    check_status("timeout");
    start_pulse();
    check_status("err_cleared");
    send_bytes(0, 4, 0, -1);
    send_bytes(5, 4, 0, -1);
    repeat (2) tick();
    check_status("after_timeout_load");

    // Asynchronous reset after three bytes of a word.
    start_pulse();
    send_bytes(1, 3, 0, -1);
    #3 reset_n = 1'b0;
    model_reset();
    #1 check_status("async_reset");
    tick();
    reset_n = 1'b1;
    tick();
    start_pulse();
    send_bytes(4, 4, 0, -1);
    repeat (2) tick();
    check_status("post_reset_word");
    send_bytes(5, 4, 0, -1);
    repeat (2) tick();
    check_status("post_reset_done");

    // Gapped stream with a start pulse in the middle of a word.
    start_pulse();
    send_bytes(0, 4, 3, -1);
    send_bytes(1, 4, 3, 2);
    send_bytes(3, 4, 3, -1);
    send_bytes(2, 4, 3, -1);
    send_bytes(5, 4, 3, -1);
    repeat (3) tick();
    check_status("backpressure");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
